// File: rtl/tlv5618a_seq.sv
// Command sequencer for the TLV5618A serial interface stage: issues a B-buffer
// write followed by an A write that updates both outputs, with one pending slot.
module tlv5618a_seq #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] ch_a,
  input  logic [11:0] ch_b,
  input  logic        speed,
  input  logic        pwr_down,
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic [15:0] dac_data,
  output logic        dac_start,
  input  logic        dac_busy
);

  typedef enum logic [3:0] {
    IDLE, SEND_B, ACK_B, DONE_B, GAP_B, SEND_A, ACK_A, DONE_A, GAP_A
  } state_t;

  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES);
  localparam logic [7:0] ACK_LIM = 8'(ACK_TIMEOUT);

  // Command bundle layout: {pwr_down, speed, ch_b, ch_a}
  state_t      state_q, state_d;
  logic [25:0] act_q, act_d;
  logic [25:0] sh_q, sh_d;
  logic        pending_q, pending_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic [15:0] data_q, data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [25:0] in_cmd;

  function automatic logic [15:0] b_word(input logic [25:0] c);
    return {1'b0, c[24], c[25], 1'b1, c[23:12]};
  endfunction

  function automatic logic [15:0] a_word(input logic [25:0] c);
    return {1'b1, c[24], c[25], 1'b0, c[11:0]};
  endfunction

  assign in_cmd  = {pwr_down, speed, ch_b, ch_a};
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    sh_d      = sh_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    error_d   = error_q;
    dac_start = 1'b0;

    if (load && state_q != IDLE) begin
      sh_d      = in_cmd;
      pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // The shadow is older than a simultaneous load, so it goes first.
        if (pending_q) begin
          act_d     = sh_q;
          pending_d = 1'b0;
          state_d   = SEND_B;
          if (load) begin
            sh_d      = in_cmd;
            pending_d = 1'b1;
          end
        end else if (load) begin
          act_d   = in_cmd;
          state_d = SEND_B;
        end
      end
      SEND_B, SEND_A: begin
        // Hold off the start pulse while the interface still reports busy.
        if (!dac_busy) begin
          dac_start = 1'b1;
          cnt_d     = 8'd0;
          state_d   = (state_q == SEND_B) ? ACK_B : ACK_A;
        end
      end
      ACK_B, ACK_A: begin
        if (dac_busy) begin
          state_d = (state_q == ACK_B) ? DONE_B : DONE_A;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= ACK_LIM) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE_B, DONE_A: begin
        if (!dac_busy) begin
          cnt_d   = GAP_LD;
          state_d = (state_q == DONE_B) ? GAP_B : GAP_A;
        end
      end
      GAP_B, GAP_A: begin
        if (cnt_q <= 8'd1) begin
          if (state_q == GAP_B) begin
            state_d = SEND_A;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word is registered on entry to SEND and held until the next SEND.
    if (state_d == SEND_B) begin
      data_d = b_word(act_d);
    end else if (state_d == SEND_A) begin
      data_d = a_word(act_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      act_q     <= '0;
      sh_q      <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      sh_q      <= sh_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ready    = (state_q == IDLE) && !pending_q;
  assign done     = done_q;
  assign error    = error_q;
  assign dac_data = data_q;

endmodule

// File: tb/tb_tlv5618a_seq.sv
// Directed bench for tlv5618a_seq with a behavioural serial interface model and
// a scoreboard of expected command words checked on every start pulse.
module tb_tlv5618a_seq;

  localparam int GAP = 4;
  localparam int ACK = 8;

  logic        clk, rst, load, speed, pwr_down;
  logic [11:0] ch_a, ch_b;
  logic        ready, done, error, dac_start, dac_busy;
  logic [15:0] dac_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int n_starts = 0;
  int fall_cyc = 0;
  bit fall_valid = 0;
  logic prev_busy = 0;

  logic [15:0] exp_q[$];
  logic [15:0] ser_q[$];

  // Interface model: one-cycle response latency, then 16 busy cycles shifting MSB-first.
  logic        busy_en;
  logic        m_busy, m_pend;
  int          m_bits;
  logic [15:0] m_word, m_rx;

  tlv5618a_seq #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst(rst), .load(load), .ch_a(ch_a), .ch_b(ch_b),
    .speed(speed), .pwr_down(pwr_down), .ready(ready), .done(done),
    .error(error), .dac_data(dac_data), .dac_start(dac_start),
    .dac_busy(dac_busy)
  );

  assign dac_busy = m_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_pend <= 1'b0; m_bits <= 0; m_word <= '0; m_rx <= '0;
    end else if (dac_start && busy_en) begin
      m_word <= dac_data;
      m_pend <= 1'b1;
    end else if (m_pend) begin
      m_pend <= 1'b0;
      m_busy <= 1'b1;
      m_bits <= 0;
    end else if (m_busy) begin
      m_rx   <= {m_rx[14:0], m_word[15-m_bits]};
      m_bits <= m_bits + 1;
      if (m_bits == 15) m_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_busy  = 1'b0;
      fall_valid = 0;
    end else begin
      if (dac_start) begin
        n_starts++;
        check("start_while_busy", {31'd0, dac_busy}, 0);
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("dac_data", {16'd0, dac_data}, {16'd0, e});
          if (busy_en) ser_q.push_back(e);
        end
        if (dac_data[15] && fall_valid) check("gap_cycles", cyc - fall_cyc, GAP + 1);
      end
      if (done) done_cnt++;
      if (prev_busy && !dac_busy) begin
        fall_cyc   = cyc;
        fall_valid = 1;
        if (ser_q.size() != 0) begin
          logic [15:0] s;
          s = ser_q.pop_front();
          check("serial_word", {16'd0, m_rx}, {16'd0, s});
        end
      end
      prev_busy = dac_busy;
    end
  end

  task automatic do_load(input logic [11:0] a, input logic [11:0] b, input logic spd, input logic pwr);
    @(negedge clk);
    ch_a = a; ch_b = b; speed = spd; pwr_down = pwr; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
    end
    check({tag, "_wait"}, {31'd0, ok}, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'd0, ready}, 1);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_error"}, {31'd0, error}, 0);
    check({tag, "_data"}, {16'd0, dac_data}, 0);
    check({tag, "_start"}, {31'd0, dac_start}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int d0, s0;
    bit ok;
    rst = 1'b0; load = 1'b0; ch_a = '0; ch_b = '0; speed = 1'b0; pwr_down = 1'b0;
    busy_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;

    // Basic pair with gap and serial checks
    exp_q.push_back(16'h5123); exp_q.push_back(16'hCABC);
    d0 = done_cnt; s0 = n_starts;
    do_load(12'hABC, 12'h123, 1'b1, 1'b0);
    check("ready_drop", {31'd0, ready}, 0);
    wait_ready(300, "t1");
    check("t1_done", done_cnt - d0, 1);
    check("t1_starts", n_starts - s0, 2);
    check("t1_ready", {31'd0, ready}, 1);
    check("t1_error", {31'd0, error}, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Three loads during the B frame: only the last survives
    exp_q.push_back(16'h10BB); exp_q.push_back(16'h80AA);
    d0 = done_cnt; s0 = n_starts;
    do_load(12'h0AA, 12'h0BB, 1'b0, 1'b0);
    do_load(12'h111, 12'h456, 1'b0, 1'b0);
    do_load(12'h222, 12'h567, 1'b1, 1'b0);
    do_load(12'h333, 12'h789, 1'b1, 1'b1);
    exp_q.push_back(16'h7789); exp_q.push_back(16'hE333);
    wait_ready(600, "t3");
    check("t3_done", done_cnt - d0, 2);
    check("t3_starts", n_starts - s0, 4);
    check("t3_sb_empty", exp_q.size(), 0);

    // Ack timeout with busy tied low; also checks the power-down B word
    busy_en = 1'b0;
    exp_q.push_back(16'h3FFF);
    s0 = n_starts;
    do_load(12'h555, 12'hFFF, 1'b0, 1'b1);
    repeat (ACK) @(negedge clk);
    check("to_error_early", {31'd0, error}, 0);
    @(negedge clk);
    check("to_error_set", {31'd0, error}, 1);
    check("to_ready", {31'd0, ready}, 1);
    repeat (30) @(negedge clk);
    check("to_no_a_start", n_starts - s0, 1);
    busy_en = 1'b1;
    exp_q.push_back(16'h500F); exp_q.push_back(16'hC0F0);
    d0 = done_cnt;
    do_load(12'h0F0, 12'h00F, 1'b1, 1'b0);
    wait_ready(300, "t4");
    check("t4_done", done_cnt - d0, 1);
    check("t4_error_sticky", {31'd0, error}, 1);
    check("t4_sb_empty", exp_q.size(), 0);

    // Reset while in DONE_A
    exp_q.push_back(16'h1654); exp_q.push_back(16'h8321);
    do_load(12'h321, 12'h654, 1'b0, 1'b0);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dac_start && dac_data[15]) begin ok = 1; break; end
    end
    check("t6_a_start_wait", {31'd0, ok}, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dac_busy) begin ok = 1; break; end
    end
    check("t6_busy_wait", {31'd0, ok}, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("midrst");
    exp_q.delete(); ser_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(16'h5DEF); exp_q.push_back(16'hC456);
    d0 = done_cnt; s0 = n_starts;
    do_load(12'h456, 12'hDEF, 1'b1, 1'b0);
    wait_ready(300, "t6");
    check("t6_done", done_cnt - d0, 1);
    check("t6_starts", n_starts - s0, 2);
    check("t6_error", {31'd0, error}, 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
